uart_frame_tx_ctrl: RTL

UART_FRAME_TX_CTRL -- requirements
Module: uart_frame_tx_ctrl

---
 rtl/uart_frame_tx_ctrl_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_frame_tx_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_frame_tx_ctrl_pkg.sv
// Shared types and defaults for the UART frame transmit controller.
// Frame layout on the wire: header, length, payload bytes, XOR checksum.
package uart_frame_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int         DEPTH_DEFAULT    = 16;
  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hAA;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Payload byte FIFO: first-word-fall-through read, pushes while full are dropped.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   cnt_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_reg == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt_reg != '0);
  assign dout    = mem[rd_ptr_reg];
  assign cnt     = cnt_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop) begin
        cnt_reg <= cnt_reg + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        cnt_reg <= cnt_reg - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx_ctrl.sv
// Frame sequencer feeding a byte-level UART transmitter: HDR, LEN, payload, CSUM.
// tx_send_en/tx_data are registered; the payload pop is aligned with tx_send_en.
module uart_frame_tx_ctrl
  import uart_frame_tx_ctrl_pkg::*;
#(
  parameter int         DEPTH    = DEPTH_DEFAULT,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  input  logic                     frame_go,
  output logic                     busy,
  output logic                     frame_done,
  output logic [7:0]               tx_data,
  output logic                     tx_send_en,
  input  logic                     tx_done,
  input  logic                     tx_busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state_reg, state_next;
  logic [7:0]    idx_reg, idx_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    csum_reg, csum_next;
  logic [7:0]    tx_data_reg, tx_data_next;
  logic          tx_send_en_reg, tx_send_en_next;
  logic          pop_reg, pop_next;
  logic          last_reg, last_next;

  logic [7:0]    fifo_dout;
  logic [CW-1:0] cnt_w;
  logic          is_csum;
  logic          is_payload;
  logic [7:0]    cur_byte;

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_en),
    .pop  (pop_reg),
    .din  (wr_data),
    .dout (fifo_dout),
    .cnt  (cnt_w),
    .full (fifo_full)
  );

  assign fifo_cnt   = cnt_w;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_FINISH);
  assign tx_data    = tx_data_reg;
  assign tx_send_en = tx_send_en_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      len_reg        <= '0;
      csum_reg       <= '0;
      tx_data_reg    <= '0;
      tx_send_en_reg <= 1'b0;
      pop_reg        <= 1'b0;
      last_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      len_reg        <= len_next;
      csum_reg       <= csum_next;
      tx_data_reg    <= tx_data_next;
      tx_send_en_reg <= tx_send_en_next;
      pop_reg        <= pop_next;
      last_reg       <= last_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    len_next        = len_reg;
    csum_next       = csum_reg;
    tx_data_next    = tx_data_reg;
    tx_send_en_next = 1'b0;
    pop_next        = 1'b0;
    last_next       = last_reg;

    // Index 0 = header, 1 = length, LEN+2 = checksum, everything between = payload.
    is_csum    = (idx_reg == len_reg + 8'd2);
    is_payload = (idx_reg >= 8'd2) && !is_csum;
    if (idx_reg == 8'd0) begin
      cur_byte = HDR_BYTE;
    end else if (idx_reg == 8'd1) begin
      cur_byte = len_reg;
    end else if (is_csum) begin
      cur_byte = csum_reg;
    end else begin
      cur_byte = fifo_dout;
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (frame_go) begin
          state_next = ST_ISSUE;
          idx_next   = '0;
          len_next   = 8'(cnt_w);
          csum_next  = 8'(cnt_w);
          last_next  = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (!tx_busy) begin
          tx_data_next    = cur_byte;
          tx_send_en_next = 1'b1;
          pop_next        = is_payload;
          last_next       = is_csum;
          idx_next        = idx_reg + 8'd1;
          state_next      = ST_WAIT;
          if (is_payload) begin
            csum_next = csum_step(csum_reg, fifo_dout);
          end
        end
      end
      ST_WAIT: begin
        if (tx_done) begin
          state_next = last_reg ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
